// File: rtl/slice_feeder.sv
// Stream-to-slice controller: turns a valid/ready pixel stream into wen/pop/wdata for a shift slice buffer
// and presents full windows to the kernel. Optional sticky short-row flag: SLICE_FEEDER_SHORT_ROW_ERR_EN.
module slice_feeder #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 3,
  parameter int CWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_last,
  output logic              wen,
  output logic              pop,
  output logic [DWIDTH-1:0] wdata,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [CWIDTH-1:0] win_col,
  output logic [1:0]        dbg_state
`ifdef SLICE_FEEDER_SHORT_ROW_ERR_EN
  ,
  output logic              short_err
`endif
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t        state;
  logic          pending;
  logic [PW-1:0] pop_cnt;
  logic          last_win;

  logic          stall;
  logic          accept;
  logic          consume;
  logic          flush_exit;
  logic          win_fire;
  logic [PW-1:0] cnt_inc;

  // Both handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and ready may drop while valid is held.
  assign stall      = win_valid & ~win_ready;
  assign s_ready    = (state != FLUSH) & ~stall & rst;
  assign accept     = s_valid & s_ready;
  assign consume    = win_valid & win_ready;
  assign flush_exit = (state == FLUSH) & ~stall;

  assign wen   = accept;
  assign wdata = s_data;
  assign pop   = (accept & pending) | flush_exit;

  assign cnt_inc  = (pop_cnt == DEPTH_C) ? DEPTH_C : pop_cnt + 1'b1;
  assign win_fire = pop & (cnt_inc == DEPTH_C);

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      pop_cnt   <= '0;
      win_valid <= 1'b0;
      win_col   <= '0;
      last_win  <= 1'b0;
`ifdef SLICE_FEEDER_SHORT_ROW_ERR_EN
      short_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= s_last ? FLUSH : FILL;
        end
        FILL: begin
          if (accept & s_last) state <= FLUSH;
          else if (win_fire)   state <= STREAM;
        end
        STREAM: begin
          if (accept & s_last) state <= FLUSH;
        end
        FLUSH: begin
          if (flush_exit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (flush_exit)  pending <= 1'b0;
      else if (accept) pending <= 1'b1;

      if (flush_exit) pop_cnt <= '0;
      else if (pop)   pop_cnt <= cnt_inc;

      if (win_fire)     win_valid <= 1'b1;
      else if (consume) win_valid <= 1'b0;

      // The window made by the trailing pop still belongs to the finished row, so the
      // column restart is deferred until that window is consumed.
      if (consume) begin
        win_col <= last_win ? '0 : win_col + 1'b1;
        if (last_win) last_win <= 1'b0;
      end
      if (flush_exit) begin
        if (win_fire) last_win <= 1'b1;
        else          win_col  <= '0;
      end

`ifdef SLICE_FEEDER_SHORT_ROW_ERR_EN
      if (flush_exit && (cnt_inc < DEPTH_C)) short_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_slice_feeder.sv
// Directed bench for slice_feeder (DEPTH=3): a model slice buffer downstream records every consumed
// window, and each test task compares what it saw against hand-computed windows and counts.
module tb_slice_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 3;
  localparam int CW    = 10;
  localparam int OW    = CW + 3 * DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          wen;
  logic          pop;
  logic [DW-1:0] wdata;
  logic          win_valid;
  logic          win_ready;
  logic [CW-1:0] win_col;
  logic [1:0]    dbg_state;
`ifdef SLICE_FEEDER_SHORT_ROW_ERR_EN
  logic          short_err;
`endif

  slice_feeder #(.DWIDTH(DW), .DEPTH(DEPTH), .CWIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .wen       (wen),
    .pop       (pop),
    .wdata     (wdata),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_col   (win_col),
    .dbg_state (dbg_state)
`ifdef SLICE_FEEDER_SHORT_ROW_ERR_EN
    ,
    .short_err (short_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  // model of the downstream shift buffer: element 0 is hidden, rdata is elements 1..DEPTH
  logic [DW-1:0] buf_e [0:DEPTH];
  logic [3*DW-1:0] win_data;
  assign win_data = {buf_e[3], buf_e[2], buf_e[1]};

  always @(posedge clk) begin
    if (pop) begin
      buf_e[3] <= buf_e[2];
      buf_e[2] <= buf_e[1];
      buf_e[1] <= buf_e[0];
    end
    if (wen) buf_e[0] <= wdata;
  end

  // scoreboard capture: every consumed window as {win_col, oldest..newest}
  int          wen_n = 0;
  int          pop_n = 0;
  int          win_n = 0;
  int          blk_n = 0;
  logic [OW-1:0] obs [0:63];
  logic [OW-1:0] exp_q [$];

  always @(negedge clk) begin
    if (rst) begin
      if (wen) wen_n <= wen_n + 1;
      if (pop) pop_n <= pop_n + 1;
      if (s_valid && !s_ready) blk_n <= blk_n + 1;
      if (win_valid && win_ready) begin
        if (win_n < 64) obs[win_n] <= {win_col, win_data};
        win_n <= win_n + 1;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [DW-1:0] d, input logic last);
    bit got;
    got = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL send_timeout data=%h s_ready=%0b required=1", d, s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    s_valid   = 1'b1;
    s_data    = 8'h77;
    win_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL rst_s_ready got=%0b want=0", s_ready); end
    total++; if (wen !== 1'b0)       begin bad++; $display("FAIL rst_wen got=%0b want=0", wen); end
    total++; if (pop !== 1'b0)       begin bad++; $display("FAIL rst_pop got=%0b want=0", pop); end
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL rst_win_valid got=%0b want=0", win_valid); end
    total++; if (win_col !== '0)     begin bad++; $display("FAIL rst_win_col got=%0d want=0", win_col); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", dbg_state); end
`ifdef SLICE_FEEDER_SHORT_ROW_ERR_EN
    total++; if (short_err !== 1'b0) begin bad++; $display("FAIL rst_short_err got=%0b want=0", short_err); end
`endif
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    rst     = 1'b1;
    idle(1);
  endtask

  task automatic test_basic;
    int w0, p0, e0;
    exp_q = {};
    exp_q.push_back({10'd0, 24'h101112});
    exp_q.push_back({10'd1, 24'h111213});
    exp_q.push_back({10'd2, 24'h121314});
    win_ready = 1'b1;
    w0 = win_n; p0 = pop_n; e0 = wen_n;
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    send(8'h14, 1'b1);
    idle(5);
    total++; if (win_n - w0 !== 3) begin bad++; $display("FAIL basic_win_count got=%0d want=3", win_n - w0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs[w0 + i] !== exp_q[i]) begin bad++; $display("FAIL basic_window%0d got=%h want=%h", i, obs[w0 + i], exp_q[i]); end
    end
    total++; if (pop_n - p0 !== 5) begin bad++; $display("FAIL basic_pops got=%0d want=5", pop_n - p0); end
    total++; if (wen_n - e0 !== 5) begin bad++; $display("FAIL basic_wens got=%0d want=5", wen_n - e0); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL basic_end_state got=%0d want=0", dbg_state); end
    total++; if (win_col !== '0) begin bad++; $display("FAIL basic_col_restart got=%0d want=0", win_col); end
`ifdef SLICE_FEEDER_SHORT_ROW_ERR_EN
    total++; if (short_err !== 1'b0) begin bad++; $display("FAIL basic_short_err got=%0b want=0", short_err); end
`endif
  endtask

  task automatic test_stall;
    int w0, p0, e0;
    int stall_bad;
    bit seen;
    bit resumed;
    exp_q = {};
    exp_q.push_back({10'd0, 24'h101112});
    exp_q.push_back({10'd1, 24'h111213});
    exp_q.push_back({10'd2, 24'h121314});
    w0 = win_n; p0 = pop_n; e0 = wen_n;
    stall_bad = 0;
    seen      = 1'b0;
    resumed   = 1'b0;
    win_ready = 1'b0;
    fork
      begin
        send(8'h10, 1'b0);
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        send(8'h13, 1'b0);
        send(8'h14, 1'b1);
      end
      begin
        for (int n = 0; n < 50; n++) begin
          @(negedge clk);
          if (win_valid) begin
            seen = 1'b1;
            break;
          end
        end
        for (int k = 0; k < 4; k++) begin
          if (s_ready || wen || pop) stall_bad++;
          if (!win_valid || win_col != '0 || win_data !== 24'h101112) stall_bad++;
          if (k < 3) @(negedge clk);
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
        @(negedge clk);
        resumed = s_ready && wen && pop && (s_data == 8'h14);
      end
    join
    idle(5);
    total++; if (!seen) begin bad++; $display("FAIL stall_first_window got=0 want=1"); end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL stall_hold errors=%0d want=0", stall_bad); end
    total++; if (!resumed) begin bad++; $display("FAIL stall_resume got=0 want=1"); end
    total++; if (win_n - w0 !== 3) begin bad++; $display("FAIL stall_win_count got=%0d want=3", win_n - w0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs[w0 + i] !== exp_q[i]) begin bad++; $display("FAIL stall_window%0d got=%h want=%h", i, obs[w0 + i], exp_q[i]); end
    end
    total++; if (pop_n - p0 !== 5) begin bad++; $display("FAIL stall_pops got=%0d want=5", pop_n - p0); end
    total++; if (wen_n - e0 !== 5) begin bad++; $display("FAIL stall_wens got=%0d want=5", wen_n - e0); end
  endtask

  task automatic test_short_row;
    int w0, p0, e0;
    win_ready = 1'b1;
    w0 = win_n; p0 = pop_n; e0 = wen_n;
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b1);
    idle(4);
    total++; if (pop_n - p0 !== 2) begin bad++; $display("FAIL short_pops got=%0d want=2", pop_n - p0); end
    total++; if (wen_n - e0 !== 2) begin bad++; $display("FAIL short_wens got=%0d want=2", wen_n - e0); end
    total++; if (win_n - w0 !== 0) begin bad++; $display("FAIL short_windows got=%0d want=0", win_n - w0); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL short_end_state got=%0d want=0", dbg_state); end
`ifdef SLICE_FEEDER_SHORT_ROW_ERR_EN
    total++; if (short_err !== 1'b1) begin bad++; $display("FAIL short_err_set got=%0b want=1", short_err); end
`endif
  endtask

  task automatic test_single;
    int w0, p0, e0;
    win_ready = 1'b1;
    w0 = win_n; p0 = pop_n; e0 = wen_n;
    send(8'h55, 1'b1);
    @(negedge clk);
    total++; if (dbg_state !== 2'd3) begin bad++; $display("FAIL single_flush_state got=%0d want=3", dbg_state); end
    total++; if (pop !== 1'b1)       begin bad++; $display("FAIL single_flush_pop got=%0b want=1", pop); end
    total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL single_flush_ready got=%0b want=0", s_ready); end
    @(negedge clk);
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL single_idle_state got=%0d want=0", dbg_state); end
    idle(3);
    total++; if (wen_n - e0 !== 1) begin bad++; $display("FAIL single_wens got=%0d want=1", wen_n - e0); end
    total++; if (pop_n - p0 !== 1) begin bad++; $display("FAIL single_pops got=%0d want=1", pop_n - p0); end
    total++; if (win_n - w0 !== 0) begin bad++; $display("FAIL single_windows got=%0d want=0", win_n - w0); end
  endtask

  task automatic test_reset_mid;
    int w0, p0, e0;
    win_ready = 1'b1;
    send(8'h20, 1'b0);
    send(8'h21, 1'b0);
    rst     = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h99;
    #1;
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL midrst_state got=%0d want=0", dbg_state); end
    total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL midrst_s_ready got=%0b want=0", s_ready); end
    total++; if (wen !== 1'b0)       begin bad++; $display("FAIL midrst_wen got=%0b want=0", wen); end
    total++; if (pop !== 1'b0)       begin bad++; $display("FAIL midrst_pop got=%0b want=0", pop); end
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL midrst_win_valid got=%0b want=0", win_valid); end
`ifdef SLICE_FEEDER_SHORT_ROW_ERR_EN
    total++; if (short_err !== 1'b0) begin bad++; $display("FAIL midrst_short_err got=%0b want=0", short_err); end
`endif
    repeat (2) @(posedge clk);
    #1;
    s_valid = 1'b0;
    rst     = 1'b1;
    idle(1);
    exp_q = {};
    exp_q.push_back({10'd0, 24'h303132});
    exp_q.push_back({10'd1, 24'h313233});
    w0 = win_n; p0 = pop_n; e0 = wen_n;
    send(8'h30, 1'b0);
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    send(8'h33, 1'b1);
    idle(5);
    total++; if (win_n - w0 !== 2) begin bad++; $display("FAIL midrst_win_count got=%0d want=2", win_n - w0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs[w0 + i] !== exp_q[i]) begin bad++; $display("FAIL midrst_window%0d got=%h want=%h", i, obs[w0 + i], exp_q[i]); end
    end
    total++; if (pop_n - p0 !== 4) begin bad++; $display("FAIL midrst_pops got=%0d want=4", pop_n - p0); end
    total++; if (wen_n - e0 !== 4) begin bad++; $display("FAIL midrst_wens got=%0d want=4", wen_n - e0); end
  endtask

  task automatic test_back_to_back;
    int w0, b0;
    win_ready = 1'b1;
    exp_q = {};
    exp_q.push_back({10'd0, 24'h404142});
    exp_q.push_back({10'd1, 24'h414243});
    exp_q.push_back({10'd0, 24'h505152});
    exp_q.push_back({10'd1, 24'h515253});
    w0 = win_n; b0 = blk_n;
    send(8'h40, 1'b0);
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b1);
    send(8'h50, 1'b0);
    send(8'h51, 1'b0);
    send(8'h52, 1'b0);
    send(8'h53, 1'b1);
    idle(5);
    total++; if (blk_n - b0 !== 1) begin bad++; $display("FAIL b2b_ready_low_cycles got=%0d want=1", blk_n - b0); end
    total++; if (win_n - w0 !== 4) begin bad++; $display("FAIL b2b_win_count got=%0d want=4", win_n - w0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs[w0 + i] !== exp_q[i]) begin bad++; $display("FAIL b2b_window%0d got=%h want=%h", i, obs[w0 + i], exp_q[i]); end
    end
  endtask

  initial begin
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    win_ready = 1'b1;
    test_reset;
    test_basic;
    test_stall;
    test_short_row;
    test_single;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
